dm_arbiter: RTL

- Sequences and shares the single-port word data memory between two requesters.
- Port 0 is the pipeline MEM stage (lw/sw); port 1 is a debug/DMA loader.
- Uses a fixed-priority grant with a starvation guard for port 1, a per-port req/ack handshake and a stall output that freezes the pipeline.
- Drives a synchronous-read memory macro with 1-cycle read latency.

---
 rtl/dm_pkg.sv | 23 ++
 rtl/dm_arbiter_if.sv | 49 ++++
 rtl/dm_arb_pick.sv | 59 +++++
 rtl/dm_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional feature macro: DM_TRACE_EN (write trace, see dm_arbiter.sv).
package dm_pkg;

  localparam int DM_ADDR_W     = 10;
  localparam int DM_DATA_W     = 32;
  localparam int DM_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } dm_state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  // A byte address is usable when word aligned and inside the 2**addr_w word array.
  function automatic logic dm_addr_ok(input logic [31:0] addr, input int addr_w);
    dm_addr_ok = (addr[1:0] == 2'b00) && ((addr >> (addr_w + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester ports and memory-macro bus of the data-memory arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface dm_arbiter_if import dm_pkg::*; #(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
);

  logic              p0_req;
  logic              p0_we;
  logic [31:0]       p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_ack;
  logic              p0_err;
  logic              p0_stall;

  logic              p1_req;
  logic              p1_we;
  logic [31:0]       p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_ack;
  logic              p1_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_rdata, p0_ack, p0_err, p0_stall,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_rdata, p1_ack, p1_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_rdata, p0_ack, p0_err, p0_stall,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_rdata, p1_ack, p1_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dm_arb_pick.sv
// Winner select for the two requesters plus the port-1 starvation counter,
// which forces port 1 ahead once it has waited STARVE_MAX cycles behind port 0.
module dm_arb_pick import dm_pkg::*; #(
  parameter int STARVE_MAX = DM_STARVE_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic p0_req_i,
  input  logic p1_req_i,
  input  logic arbitrate_i,
  input  logic busy_by_p0_i,
  output logic winner_o
);

  localparam int            CW   = $clog2(STARVE_MAX + 2);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;
  logic          p0_wins_s;
  logic          p1_wins_s;

  // Fixed priority to port 0 unless port 1 has saturated its wait count.
  always_comb begin
    winner_o = P0;
    if (p0_req_i && p1_req_i) begin
      winner_o = (starve_q == SMAX) ? P1 : P0;
    end else if (p1_req_i) begin
      winner_o = P1;
    end else begin
      winner_o = P0;
    end
  end

  assign p0_wins_s = arbitrate_i && p0_req_i && (winner_o == P0);
  assign p1_wins_s = arbitrate_i && p1_req_i && (winner_o == P1);

  // Count cycles port 1 spends waiting behind port 0; cleared on its grant or withdrawal.
  always_comb begin
    starve_d = starve_q;
    if (!p1_req_i || p1_wins_s) begin
      starve_d = '0;
    end else if ((busy_by_p0_i || p0_wins_s) && (starve_q != SMAX)) begin
      starve_d = starve_q + CW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares a single-port synchronous-read word memory between the pipeline MEM
// stage (port 0) and a debug/DMA loader (port 1); each access takes 3 cycles.
// Define DM_TRACE_EN to print one line per memory write.
module dm_arbiter import dm_pkg::*; #(
  parameter int ADDR_W     = DM_ADDR_W,
  parameter int DATA_W     = DM_DATA_W,
  parameter int STARVE_MAX = DM_STARVE_MAX
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);

  dm_state_e         state_q, state_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic              ok_q, ok_d;
  logic              rd_q, rd_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic              p0_err_q, p0_err_d;
  logic              p1_err_q, p1_err_d;

  logic              winner_s;
  logic              arbitrate_s;
  logic              busy_by_p0_s;
  logic              sel_we_s;
  logic [31:0]       sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_ok_s;

  assign arbitrate_s  = (state_q == IDLE);
  assign busy_by_p0_s = ((state_q == ISSUE) || (state_q == WAIT)) && (grant_q == P0);

  dm_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk          (clk),
    .reset        (reset),
    .p0_req_i     (bus.p0_req),
    .p1_req_i     (bus.p1_req),
    .arbitrate_i  (arbitrate_s),
    .busy_by_p0_i (busy_by_p0_s),
    .winner_o     (winner_s)
  );

  // Fields of whichever port wins this arbitration.
  always_comb begin
    if (winner_s == P1) begin
      sel_we_s    = bus.p1_we;
      sel_addr_s  = bus.p1_addr;
      sel_wdata_s = bus.p1_wdata;
    end else begin
      sel_we_s    = bus.p0_we;
      sel_addr_s  = bus.p0_addr;
      sel_wdata_s = bus.p0_wdata;
    end
    sel_ok_s = dm_addr_ok(sel_addr_s, ADDR_W);
  end

  // Next state; memory strobes and acks are one-cycle pulses defaulting to 0.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    we_d        = we_q;
    ok_d        = ok_q;
    rd_d        = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    p0_err_d    = 1'b0;
    p1_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          grant_d = winner_s;
          we_d    = sel_we_s;
          ok_d    = sel_ok_s;
          state_d = ISSUE;
          // Invalid addresses never reach the macro.
          if (sel_ok_s) begin
            mem_en_d    = 1'b1;
            mem_we_d    = sel_we_s;
            mem_addr_d  = sel_addr_s[ADDR_W+1:2];
            mem_wdata_d = sel_we_s ? sel_wdata_s : '0;
          end else begin
            mem_en_d    = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d  = WAIT;
        rd_d     = ok_q && !we_q;
        p0_ack_d = (grant_q == P0);
        p1_ack_d = (grant_q == P1);
        p0_err_d = (grant_q == P0) && !ok_q;
        p1_err_d = (grant_q == P1) && !ok_q;
      end
      WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef DM_TRACE_EN
  logic [31:0] trace_addr_s;
  assign trace_addr_s = {{(30-ADDR_W){1'b0}}, mem_addr_q, 2'b00};
`endif

  // FSM and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= P0;
      we_q        <= 1'b0;
      ok_q        <= 1'b0;
      rd_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      ok_q        <= ok_d;
      rd_q        <= rd_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      p0_err_q    <= p0_err_d;
      p1_err_q    <= p1_err_d;
`ifdef DM_TRACE_EN
      if ((state_q == ISSUE) && mem_we_q) begin
        $display("%d@p%0d: *%h <= %h", $time, grant_q, trace_addr_s, mem_wdata_q);
      end
`endif
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Read data comes straight from the macro during the ack cycle.
  assign bus.p0_rdata = (p0_ack_q && rd_q) ? bus.mem_rdata : '0;
  assign bus.p1_rdata = (p1_ack_q && rd_q) ? bus.mem_rdata : '0;
  assign bus.p0_ack   = p0_ack_q;
  assign bus.p1_ack   = p1_ack_q;
  assign bus.p0_err   = p0_err_q;
  assign bus.p1_err   = p1_err_q;
  assign bus.p0_stall = bus.p0_req && !p0_ack_q;

endmodule
